conflict_detector_mc: RTL

Multi-channel, backtrack-aware implication conflict detector for the SAT solver datapath. It accepts up to NUM_CH implications per cycle from parallel clause evaluators and records each variable's implied value and decision level. It flags any contradiction to the solver, and serialises new, non-redundant implications into a FIFO that drains one per cycle toward the imply stack. On solver backtrack it invalidates every entry above a target level in one cycle, so the table never needs a full reset between decisions.

---
 rtl/conflict_detector_mc_if.sv | 38 +++
 rtl/conflict_detector_mc.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/conflict_detector_mc_if.sv
// Implication / FIFO / backtrack bus between the clause evaluators, the
// solver control and the conflict detector.
`ifndef MAX_VARS
`define MAX_VARS 64
`endif
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 6
`endif

interface conflict_detector_mc_if #(
  parameter int NUM_CH     = 2,
  parameter int VAR_BITS   = `MAX_VARS_BITS,
  parameter int LEVEL_BITS = `MAX_VARS_BITS
);
  logic [NUM_CH-1:0]          in_valid;
  logic [NUM_CH*VAR_BITS-1:0] in_var;
  logic [NUM_CH-1:0]          in_val;
  logic                       in_ready;
  logic [LEVEL_BITS-1:0]      cur_level;
  logic                       bt_en;
  logic [LEVEL_BITS-1:0]      bt_level;
  logic                       conflict;
  logic [VAR_BITS-1:0]        conflict_var;
  logic                       out_valid;
  logic [VAR_BITS-1:0]        out_var;
  logic                       out_val;
  logic                       out_ready;

  modport master (
    output in_valid, in_var, in_val, cur_level, bt_en, bt_level, out_ready,
    input  in_ready, conflict, conflict_var, out_valid, out_var, out_val
  );

  modport slave (
    input  in_valid, in_var, in_val, cur_level, bt_en, bt_level, out_ready,
    output in_ready, conflict, conflict_var, out_valid, out_var, out_val
  );
endinterface

// File: rtl/conflict_detector_mc.sv
// Multi-channel implication conflict detector. Keeps {valid, val, level}
// per variable, flags contradictions (sticky until backtrack), queues new
// implications in channel order and invalidates levels above a backtrack
// target in a single cycle.
`ifndef MAX_VARS
`define MAX_VARS 64
`endif
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 6
`endif

module conflict_detector_mc #(
  parameter int NUM_VARS   = `MAX_VARS,
  parameter int VAR_BITS   = `MAX_VARS_BITS,
  parameter int NUM_CH     = 2,
  parameter int LEVEL_BITS = `MAX_VARS_BITS,
  parameter int FIFO_DEPTH = 8
) (
  input logic             clock,
  input logic             reset,
  conflict_detector_mc_if.slave bus
);

  localparam int PTR_BITS = $clog2(FIFO_DEPTH);
  localparam int CNT_BITS = PTR_BITS + 1;
  localparam logic [CNT_BITS-1:0] DEPTH_C = CNT_BITS'(FIFO_DEPTH);
  localparam logic [CNT_BITS-1:0] NCH_C   = CNT_BITS'(NUM_CH);

  // Variable table
  logic                  tbl_valid [NUM_VARS];
  logic                  tbl_val   [NUM_VARS];
  logic [LEVEL_BITS-1:0] tbl_level [NUM_VARS];

  // Output FIFO
  logic [VAR_BITS-1:0] fifo_var [FIFO_DEPTH];
  logic                fifo_val [FIFO_DEPTH];
  logic [PTR_BITS-1:0] wr_ptr, rd_ptr;
  logic [CNT_BITS-1:0] count;

  logic                conflict_q;
  logic [VAR_BITS-1:0] conflict_var_q;

  // Per-cycle decode
  logic [VAR_BITS-1:0] ch_var  [NUM_CH];
  logic [PTR_BITS-1:0] wr_addr [NUM_CH];
  logic [NUM_CH-1:0]   acc, offend, push;
  logic [CNT_BITS-1:0] n_push;
  logic [VAR_BITS-1:0] conf_var_nx;
  logic                any_conf, in_ready_c, out_valid_c, pop;

  // Split the packed channel bus into per-channel variable indices.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ch_var[i] = bus.in_var[i*VAR_BITS +: VAR_BITS];
    end
  end

  // Acceptance, table check, same-cycle channel interactions and FIFO slots.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a value unassigned, which is what keeps it from becoming a latch.
    in_ready_c  = !conflict_q && !bus.bt_en && ((DEPTH_C - count) >= NCH_C);
    out_valid_c = (count != '0);
    pop         = out_valid_c && bus.out_ready;
    acc         = '0;
    offend      = '0;
    push        = '0;
    n_push      = '0;
    conf_var_nx = '0;
    any_conf    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_addr[i] = '0;
    end

    for (int i = 0; i < NUM_CH; i++) begin
      acc[i]    = bus.in_valid[i] && in_ready_c;
      offend[i] = acc[i] && tbl_valid[ch_var[i]] &&
                  (tbl_val[ch_var[i]] != bus.in_val[i]);
      push[i]   = acc[i] && !tbl_valid[ch_var[i]];
      // A lower channel on the same variable either contradicts this one or
      // already carries the push.
      for (int j = 0; j < i; j++) begin
        if (acc[j] && acc[i] && (ch_var[j] == ch_var[i])) begin
          if (bus.in_val[j] != bus.in_val[i]) begin
            offend[j] = 1'b1;
            offend[i] = 1'b1;
          end else begin
            push[i] = 1'b0;
          end
        end
      end
    end

    any_conf = |offend;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (offend[i]) conf_var_nx = ch_var[i];
    end

    // Pushes land in consecutive slots in ascending channel order.
    for (int i = 0; i < NUM_CH; i++) begin
      wr_addr[i] = wr_ptr + n_push[PTR_BITS-1:0];
      if (push[i]) n_push = n_push + 1'b1;
    end
  end

  // Table valid bits: backtrack invalidation or marking new implications.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: state is updated with non-blocking assignments only, so every
    // read in this edge sees the pre-edge table.
    if (reset) begin
      for (int v = 0; v < NUM_VARS; v++) tbl_valid[v] <= 1'b0;
    end else if (bus.bt_en) begin
      for (int v = 0; v < NUM_VARS; v++) begin
        if (tbl_level[v] > bus.bt_level) tbl_valid[v] <= 1'b0;
      end
    end else if (!any_conf) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (push[i]) tbl_valid[ch_var[i]] <= 1'b1;
      end
    end
  end

  // Table payload for new implications.
  always_ff @(posedge clock) begin
    // NOTE: payload storage has no reset; the valid bits above qualify it.
    if (!any_conf) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (push[i]) begin
          tbl_val[ch_var[i]]   <= bus.in_val[i];
          tbl_level[ch_var[i]] <= bus.cur_level;
        end
      end
    end
  end

  // FIFO storage writes.
  always_ff @(posedge clock) begin
    if (!any_conf) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (push[i]) begin
          fifo_var[wr_addr[i]] <= ch_var[i];
          fifo_val[wr_addr[i]] <= bus.in_val[i];
        end
      end
    end
  end

  // FIFO pointers and occupancy; backtrack and conflict both flush.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.bt_en || any_conf) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + n_push[PTR_BITS-1:0];
      rd_ptr <= rd_ptr + PTR_BITS'(pop);
      count  <= count + n_push - CNT_BITS'(pop);
    end
  end

  // Sticky conflict flag, cleared only by backtrack.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      conflict_q     <= 1'b0;
      conflict_var_q <= '0;
    end else if (bus.bt_en) begin
      conflict_q     <= 1'b0;
      conflict_var_q <= '0;
    end else if (any_conf) begin
      conflict_q     <= 1'b1;
      conflict_var_q <= conf_var_nx;
    end
  end

  assign bus.in_ready     = in_ready_c;
  assign bus.conflict     = conflict_q;
  assign bus.conflict_var = conflict_var_q;
  assign bus.out_valid    = out_valid_c;
  assign bus.out_var      = out_valid_c ? fifo_var[rd_ptr] : '0;
  assign bus.out_val      = out_valid_c ? fifo_val[rd_ptr] : 1'b0;

endmodule
